// File: rtl/adc_pkg.sv
// adc_pkg: capture FSM state type and default widths shared by the ADC capture buffer.
package adc_pkg;
    localparam int ADC_DW = 12;
    localparam int ADC_AW = 12;
    typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, DONE} capture_state_t;
endpackage

// File: rtl/adc_dp_ram.sv
// adc_dp_ram: simple dual-port RAM, one write port and one registered read-first read port, no reset.
module adc_dp_ram
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DW,
    parameter int ADDR_WIDTH = ADC_AW
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: pre/post-trigger circular capture buffer with registered read port.
// Optional rising-level trigger comparator enabled by defining ADC_CAPTURE_LEVEL_TRIG_EN.
module adc_capture_buffer
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH = ADC_DW,
    parameter int ADDR_WIDTH = ADC_AW
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_data_i,
    input  logic                  arm_i,
    input  logic                  ext_trig_i,
    input  logic                  force_trig_i,
    input  logic [ADDR_WIDTH-1:0] pre_count_i,
    input  logic [ADDR_WIDTH-1:0] post_count_i,
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    input  logic [DATA_WIDTH-1:0] trig_level_i,
    input  logic                  trig_level_en_i,
`endif
    output logic                  busy_o,
    output logic                  capture_done_o,
    output logic [ADDR_WIDTH-1:0] trig_addr_o,
    output logic [ADDR_WIDTH-1:0] start_addr_o,
    input  logic                  read_en_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  read_valid_o
);
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = '1;
    capture_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, pre_q, pre_d, post_q, post_d, cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d, start_addr_q, start_addr_d, room, post_lim;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic pend_q, pend_d, read_valid_q, wr_en, arm_ok, level_hit, trig_hit;

    assign wr_en    = busy_o & sample_valid_i;
    assign arm_ok   = arm_i & (state_q == IDLE | state_q == DONE);
    assign room     = MAX_ADDR - pre_count_i;
    assign post_lim = (post_count_i > room) ? room : post_count_i;
    assign trig_hit = sample_valid_i & (ext_trig_i | force_trig_i | pend_q | level_hit);

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    logic [DATA_WIDTH-1:0] prev_q;
    logic prev_ok_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else begin
            if (sample_valid_i) prev_q <= sample_data_i;
            prev_ok_q <= arm_ok ? 1'b0 : (prev_ok_q | sample_valid_i);
        end
    end
    assign level_hit = trig_level_en_i & prev_ok_q & (prev_q < trig_level_i) & (trig_level_i <= sample_data_i);
`else
    assign level_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            pre_q        <= '0;
            post_q       <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            pend_q       <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_q        <= pre_d;
            post_q       <= post_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            pend_q       <= pend_d;
            read_valid_q <= read_en_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        pre_d        = pre_q;
        post_d       = post_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        pend_d       = 1'b0;
        case (state_q)
            IDLE, DONE: if (arm_i) begin
                pre_d   = pre_count_i;
                post_d  = post_lim;
                cnt_d   = '0;
                state_d = (pre_count_i == '0) ? WAIT_TRIG : PREFILL;
            end
            PREFILL: if (sample_valid_i) begin
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                state_d = (cnt_d == pre_q) ? WAIT_TRIG : PREFILL;
            end
            WAIT_TRIG: begin
                pend_d = (pend_q | force_trig_i) & ~trig_hit;
                if (trig_hit) begin
                    trig_addr_d  = wr_ptr_q;
                    start_addr_d = wr_ptr_q - pre_q;
                    cnt_d        = '0;
                    state_d      = (post_q == '0) ? DONE : POST;
                end
            end
            POST: if (sample_valid_i) begin
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                state_d = (cnt_d == post_q) ? DONE : POST;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is forced to zero while not valid so reset leaves every output at 0.
    always_comb begin
        busy_o         = (state_q == PREFILL) | (state_q == WAIT_TRIG) | (state_q == POST);
        capture_done_o = state_q == DONE;
        trig_addr_o    = trig_addr_q;
        start_addr_o   = start_addr_q;
        read_valid_o   = read_valid_q;
        read_data_o    = read_valid_q ? ram_rdata : '0;
    end

    adc_dp_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_data_i),
        .re_i    (read_en_i),
        .raddr_i (read_addr_i),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: table-driven and randomized checks of the capture buffer against a window model.
module tb_adc_capture_buffer;
    localparam int D = 4096;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic sample_valid_i = 0, arm_i = 0, ext_trig_i = 0, force_trig_i = 0, read_en_i = 0;
    logic [11:0] sample_data_i = '0, pre_count_i = '0, post_count_i = '0, read_addr_i = '0;
    logic busy_o, capture_done_o, read_valid_o;
    logic [11:0] trig_addr_o, start_addr_o, read_data_o;
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    logic [11:0] trig_level_i = '0;
    logic trig_level_en_i = 1'b0;
`endif
    int n_cmp = 0, n_bad = 0, mp = 0, gap_pct = 0;
    logic [11:0] mm [D];

    typedef struct {
        int pre, postq, t, exp_post;
        bit frc, ramp, arm_mid;
        int early, exp_trig, exp_start;
    } vec_t;
    vec_t tbl [5];

    always #5 clk_i = ~clk_i;

    adc_capture_buffer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i),
        .arm_i(arm_i), .ext_trig_i(ext_trig_i), .force_trig_i(force_trig_i),
        .pre_count_i(pre_count_i), .post_count_i(post_count_i),
`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
        .trig_level_i(trig_level_i), .trig_level_en_i(trig_level_en_i),
`endif
        .busy_o(busy_o), .capture_done_o(capture_done_o), .trig_addr_o(trig_addr_o),
        .start_addr_o(start_addr_o), .read_en_i(read_en_i), .read_addr_i(read_addr_i),
        .read_data_o(read_data_o), .read_valid_o(read_valid_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic rd(input int a);
        read_en_i = 1;
        read_addr_i = 12'(a);
        step();
        read_en_i = 0;
        chk("rd_valid", int'(read_valid_o), 1);
        chk($sformatf("rd_data@%0d", a), int'(read_data_o), int'(mm[a]));
    endtask

    // One full capture: arm, stream t+1+npost samples (trigger on sample t), check completion.
    task automatic run(input int pre, input int postq, input int t, input int npost, input bit frc,
                       input int early, input bit ramp, input bit arm_mid, output int gt, output int gs);
        int p0;
        p0 = mp;
        arm_i = 1;
        pre_count_i = 12'(pre);
        post_count_i = 12'(postq);
        step();
        arm_i = 0;
        for (int i = 0; i <= t + npost; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                sample_valid_i = 0;
                step();
            end
            if (frc && i == t) begin
                sample_valid_i = 0;
                force_trig_i = 1;
                step();
                force_trig_i = 0;
                if ($urandom_range(1) == 1) step();
            end
            sample_valid_i = 1;
            sample_data_i = ramp ? 12'((p0 + i) % D) : 12'($urandom);
            ext_trig_i = (!frc && i == t) || i == early;
            arm_i = arm_mid && i == 1;
            if (arm_i) begin
                pre_count_i = 12'd7;
                post_count_i = 12'd1;
            end
            mm[(p0 + i) % D] = sample_data_i;
            if (i == t + npost) chk("not_done_early", int'(capture_done_o), 0);
            step();
        end
        sample_valid_i = 0;
        ext_trig_i = 0;
        arm_i = 0;
        mp = (p0 + t + 1 + npost) % D;
        chk("done", int'(capture_done_o), 1);
        chk("busy_after", int'(busy_o), 0);
        gt = int'(trig_addr_o);
        gs = int'(start_addr_o);
    endtask

    initial begin
        int gt, gs, pre, postq, t, np, p0, old;
        tbl[0] = '{4, 3, 10, 3, 1'b1, 1'b1, 1'b0, -1, 10, 6};
        tbl[1] = '{0, 0, 0, 0, 1'b0, 1'b1, 1'b0, -1, 14, 14};
        tbl[2] = '{3000, 3000, 3000, 1095, 1'b0, 1'b0, 1'b1, 5, 3015, 15};
        tbl[3] = '{0, 4078, 0, 4078, 1'b0, 1'b0, 1'b0, -1, 15, 15};
        tbl[4] = '{4, 5, 4, 5, 1'b0, 1'b1, 1'b0, -1, 2, 4094};
        repeat (2) step();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(capture_done_o), 0);
        chk("rst_trig", int'(trig_addr_o), 0);
        chk("rst_start", int'(start_addr_o), 0);
        chk("rst_rvalid", int'(read_valid_o), 0);
        rst_ni = 1;
        step();

        for (int r = 0; r < 5; r++) begin
            run(tbl[r].pre, tbl[r].postq, tbl[r].t, tbl[r].exp_post, tbl[r].frc, tbl[r].early,
                tbl[r].ramp, tbl[r].arm_mid, gt, gs);
            chk($sformatf("row%0d_trig", r), gt, tbl[r].exp_trig);
            chk($sformatf("row%0d_start", r), gs, tbl[r].exp_start);
            for (int k = 0; k < 6 && k < tbl[r].pre + 1 + tbl[r].exp_post; k++)
                rd((tbl[r].exp_start + k) % D);
        end

        gap_pct = 25;
        for (int r = 0; r < 6; r++) begin
            pre = int'($urandom_range(20));
            postq = int'($urandom_range(20));
            t = pre + int'($urandom_range(6));
            np = (postq < D - 1 - pre) ? postq : D - 1 - pre;
            p0 = mp;
            run(pre, postq, t, np, 1'($urandom_range(1)), -1, 1'b0, 1'b0, gt, gs);
            chk($sformatf("rnd%0d_trig", r), gt, (p0 + t) % D);
            chk($sformatf("rnd%0d_start", r), gs, (p0 + t - pre + D) % D);
            repeat (3) rd((p0 + t - pre + int'($urandom_range(pre + np)) + D) % D);
        end
        gap_pct = 0;

        // pre=0/post=0 capture: busy for one cycle, write and read of the same address in that cycle.
        arm_i = 1;
        pre_count_i = 0;
        post_count_i = 0;
        step();
        arm_i = 0;
        chk("p0_busy", int'(busy_o), 1);
        old = int'(mm[mp]);
        sample_valid_i = 1;
        ext_trig_i = 1;
        sample_data_i = ~mm[mp];
        read_en_i = 1;
        read_addr_i = 12'(mp);
        step();
        sample_valid_i = 0;
        ext_trig_i = 0;
        read_en_i = 0;
        chk("p0_done", int'(capture_done_o), 1);
        chk("p0_trig", int'(trig_addr_o), mp);
        chk("rf_valid", int'(read_valid_o), 1);
        chk("rf_old_data", int'(read_data_o), old);
        mm[mp] = sample_data_i;
        rd(mp);
        mp = (mp + 1) % D;

        // Reset while in POST, then a normal capture from wr_ptr 0.
        arm_i = 1;
        pre_count_i = 2;
        post_count_i = 50;
        step();
        arm_i = 0;
        for (int i = 0; i < 6; i++) begin
            sample_valid_i = 1;
            sample_data_i = 12'($urandom);
            ext_trig_i = i == 2;
            mm[(mp + i) % D] = sample_data_i;
            step();
        end
        sample_valid_i = 0;
        ext_trig_i = 0;
        chk("mid_busy", int'(busy_o), 1);
        read_en_i = 1;
        read_addr_i = 0;
        step();
        read_en_i = 0;
        #2 rst_ni = 0;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_done", int'(capture_done_o), 0);
        chk("mid_rst_rvalid", int'(read_valid_o), 0);
        chk("mid_rst_trig", int'(trig_addr_o), 0);
        step();
        rst_ni = 1;
        mp = 0;
        step();
        run(3, 4, 5, 4, 1'b0, -1, 1'b1, 1'b0, gt, gs);
        chk("rearm_trig", gt, 5);
        chk("rearm_start", gs, 2);
        rd(2);

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
        p0 = mp;
        trig_level_i = 12'd100;
        trig_level_en_i = 1;
        arm_i = 1;
        pre_count_i = 0;
        post_count_i = 0;
        step();
        arm_i = 0;
        for (int v = 90; v <= 110 && !capture_done_o; v++) begin
            sample_valid_i = 1;
            sample_data_i = 12'(v);
            mm[mp] = sample_data_i;
            mp = (mp + 1) % D;
            step();
        end
        sample_valid_i = 0;
        trig_level_en_i = 0;
        chk("lvl_done", int'(capture_done_o), 1);
        chk("lvl_trig", int'(trig_addr_o), (p0 + 10) % D);
        rd((p0 + 10) % D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
